// File: rtl/mystic_alu_issue.sv
// Single-outstanding ALU issue and writeback sequencer (IDLE -> ISSUE -> WAIT -> RESP).
// Optional WAIT watchdog is compiled in when MYSTIC_ALU_TIMEOUT_EN is defined.
module mystic_alu_issue #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [5:0]  req_opcode_i,
   input  logic [63:0] req_srcA_i,
   input  logic [63:0] req_srcB_i,
   input  logic [4:0]  req_rd_i,
   output logic [5:0]  alu_opcode_o,
   output logic        alu_opcode_valid_o,
   output logic [63:0] alu_srcA_o,
   output logic [63:0] alu_srcB_o,
   input  logic [63:0] alu_result_i,
   input  logic        alu_ready_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [63:0] wb_data_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic        ready_r;
   logic        issue_r;
   logic        wb_valid_r;
   logic        wb_err_r;
   logic [5:0]  op_r;
   logic [63:0] src_a_r;
   logic [63:0] src_b_r;
   logic [4:0]  rd_r;
   logic [63:0] wb_data_r;
   logic        accept_s;
   logic        illegal_s;
   logic        alu_done_s;
   logic        timeout_s;

   // ready_r stays low for the first cycle after reset so nothing is accepted while outputs are still cleared
   assign accept_s   = (state_r == ST_IDLE) && ready_r && req_valid_i;
   assign illegal_s  = (req_opcode_i > 6'd7);
   assign alu_done_s = (state_r == ST_WAIT) && alu_ready_i;

`ifdef MYSTIC_ALU_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST_C = 8'(TIMEOUT_CYCLES - 32'd1);
   logic [7:0] wdog_cnt_r;

   // Watchdog: zero outside WAIT, counts WAIT cycles that pass without an ALU response
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdog_cnt_r <= 8'd0;
      end else if (state_r != ST_WAIT) begin
         wdog_cnt_r <= 8'd0;
      end else if (!alu_ready_i) begin
         wdog_cnt_r <= wdog_cnt_r + 8'd1;
      end else begin
         wdog_cnt_r <= wdog_cnt_r;
      end
   end

   // A response arriving on the expiry cycle takes priority over the abort
   assign timeout_s = (state_r == ST_WAIT) && !alu_ready_i && (wdog_cnt_r == TIMEOUT_LAST_C);
`else
   logic [7:0] timeout_unused_s;
   assign timeout_unused_s = 8'(TIMEOUT_CYCLES);
   assign timeout_s        = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = illegal_s ? ST_RESP : ST_ISSUE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ISSUE: next_state_s = ST_WAIT;
         ST_WAIT: begin
            if (alu_done_s || timeout_s) begin
               next_state_s = ST_RESP;
            end else begin
               next_state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (wb_ready_i) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register and state-decoded handshake outputs, registered from the next state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         ready_r    <= 1'b0;
         issue_r    <= 1'b0;
         wb_valid_r <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         ready_r    <= (next_state_s == ST_IDLE);
         issue_r    <= (next_state_s == ST_ISSUE);
         wb_valid_r <= (next_state_s == ST_RESP);
      end
   end

   // Operand capture on accept; result/error capture on completion, illegal opcode or timeout
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_r      <= 6'd0;
         src_a_r   <= 64'd0;
         src_b_r   <= 64'd0;
         rd_r      <= 5'd0;
         wb_data_r <= 64'd0;
         wb_err_r  <= 1'b0;
      end else begin
         if (accept_s) begin
            op_r    <= req_opcode_i;
            src_a_r <= req_srcA_i;
            src_b_r <= req_srcB_i;
            rd_r    <= req_rd_i;
         end
         if (accept_s) begin
            wb_data_r <= 64'd0;
            wb_err_r  <= illegal_s;
         end else if (alu_done_s) begin
            wb_data_r <= alu_result_i;
            wb_err_r  <= 1'b0;
         end else if (timeout_s) begin
            wb_data_r <= 64'd0;
            wb_err_r  <= 1'b1;
         end
      end
   end

   assign req_ready_o        = ready_r;
   assign alu_opcode_valid_o = issue_r;
   assign alu_opcode_o       = op_r;
   assign alu_srcA_o         = src_a_r;
   assign alu_srcB_o         = src_b_r;
   assign wb_valid_o         = wb_valid_r;
   assign wb_data_o          = wb_data_r;
   assign wb_rd_o            = rd_r;
   assign wb_err_o           = wb_err_r;

endmodule

// File: tb/tb_mystic_alu_issue.sv
// Self-checking bench for mystic_alu_issue: directed and random operations against a
// behavioural ALU/latency model; honours MYSTIC_ALU_TIMEOUT_EN for the watchdog case.
module tb_mystic_alu_issue;

   localparam int TO_C = 15;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [5:0]  req_opcode_i;
   logic [63:0] req_srcA_i;
   logic [63:0] req_srcB_i;
   logic [4:0]  req_rd_i;
   logic [5:0]  alu_opcode_o;
   logic        alu_opcode_valid_o;
   logic [63:0] alu_srcA_o;
   logic [63:0] alu_srcB_o;
   logic [63:0] alu_result_i;
   logic        alu_ready_i;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [63:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   logic        wb_err_o;

   int n_cmp = 0;
   int n_err = 0;
   bit alu_respond = 1'b1;

   mystic_alu_issue #(.TIMEOUT_CYCLES(TO_C)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .req_valid_i        (req_valid_i),
      .req_ready_o        (req_ready_o),
      .req_opcode_i       (req_opcode_i),
      .req_srcA_i         (req_srcA_i),
      .req_srcB_i         (req_srcB_i),
      .req_rd_i           (req_rd_i),
      .alu_opcode_o       (alu_opcode_o),
      .alu_opcode_valid_o (alu_opcode_valid_o),
      .alu_srcA_o         (alu_srcA_o),
      .alu_srcB_o         (alu_srcB_o),
      .alu_result_i       (alu_result_i),
      .alu_ready_i        (alu_ready_i),
      .wb_valid_o         (wb_valid_o),
      .wb_ready_i         (wb_ready_i),
      .wb_data_o          (wb_data_o),
      .wb_rd_o            (wb_rd_o),
      .wb_err_o           (wb_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Architectural ALU semantics (shift amount = low 6 bits of srcB)
   function automatic logic [63:0] ref_alu(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
      int unsigned sh;
      sh = 32'(b[5:0]);
      case (op)
         6'd0:    return a + b;
         6'd1:    return a & b;
         6'd2:    return a | b;
         6'd3:    return a << sh;
         6'd4:    return 64'($signed(a) >>> sh);
         6'd5:    return a >> sh;
         6'd6:    return a ^ b;
         6'd7:    return a - b;
         default: return 64'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // External ALU model: samples operands the cycle after the strobe, answers two cycles after issue
   initial begin : alu_model
      logic [5:0]  m_op;
      logic [63:0] m_a;
      logic [63:0] m_b;
      alu_ready_i  = 1'b0;
      alu_result_i = 64'd0;
      forever begin
         @(negedge clk_i);
         if (alu_opcode_valid_o === 1'b1 && alu_respond) begin
            @(posedge clk_i);
            @(negedge clk_i);
            m_op = alu_opcode_o;
            m_a  = alu_srcA_o;
            m_b  = alu_srcB_o;
            @(posedge clk_i); #1;
            alu_ready_i  = 1'b1;
            alu_result_i = ref_alu(m_op, m_a, m_b);
            @(posedge clk_i); #1;
            alu_ready_i  = 1'b0;
            alu_result_i = {$urandom(), $urandom()};
         end
      end
   end

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_req_ready",  64'(req_ready_o), 64'd0);
      check("rst_wb_valid",   64'(wb_valid_o), 64'd0);
      check("rst_strobe",     64'(alu_opcode_valid_o), 64'd0);
      check("rst_wb_data",    wb_data_o, 64'd0);
      check("rst_wb_err",     64'(wb_err_o), 64'd0);
      check("rst_wb_rd",      64'(wb_rd_o), 64'd0);
      check("rst_alu_srcA",   alu_srcA_o, 64'd0);
      check("rst_alu_opcode", 64'(alu_opcode_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("post_rst_ready", 64'(req_ready_o), 64'd1);
      check("post_rst_wb_valid", 64'(wb_valid_o), 64'd0);
   endtask

   // One request end to end; hold = cycles wb_ready_i is kept low once wb_valid_o rises
   task automatic run_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int hold, input bit alu_on);
      bit          legal;
      int          lat;
      int          exp_lat;
      int          guard;
      logic [63:0] exp_data;
      logic        exp_err;
      legal       = (op < 6'd8);
      alu_respond = alu_on;
      if (!legal) exp_lat = 0;
      else if (alu_on) exp_lat = 3;
      else begin
`ifdef MYSTIC_ALU_TIMEOUT_EN
         exp_lat = TO_C + 1;
`else
         exp_lat = -1;
`endif
      end
      exp_err  = !legal || !alu_on;
      exp_data = (legal && alu_on) ? ref_alu(op, a, b) : 64'd0;

      guard = 0;
      while (req_ready_o !== 1'b1 && guard < 20) begin
         @(posedge clk_i); #1;
         guard++;
      end
      check("ready_before_req", 64'(req_ready_o), 64'd1);
      @(negedge clk_i);
      req_valid_i  = 1'b1;
      req_opcode_i = op;
      req_srcA_i   = a;
      req_srcB_i   = b;
      req_rd_i     = rd;
      @(posedge clk_i); #1;
      req_valid_i  = 1'b0;
      req_opcode_i = 6'($urandom());
      req_srcA_i   = {$urandom(), $urandom()};
      req_srcB_i   = {$urandom(), $urandom()};
      req_rd_i     = 5'($urandom());
      check("issue_strobe", 64'(alu_opcode_valid_o), 64'(legal));
      check("busy_not_ready", 64'(req_ready_o), 64'd0);

      lat = 0;
      while (wb_valid_o !== 1'b1 && lat < 100) begin
         @(posedge clk_i); #1;
         lat++;
         if (legal && lat == 1) check("strobe_one_cycle", 64'(alu_opcode_valid_o), 64'd0);
         if (legal && lat <= 2) begin
            check("alu_opcode_held", 64'(alu_opcode_o), 64'(op));
            check("alu_srcA_held", alu_srcA_o, a);
            check("alu_srcB_held", alu_srcB_o, b);
         end
      end

      if (exp_lat < 0) begin
         check("no_wb_without_watchdog", 64'(wb_valid_o), 64'd0);
         check("stuck_not_ready", 64'(req_ready_o), 64'd0);
         do_reset();
         return;
      end

      check("wb_latency", 64'(lat), 64'(exp_lat));
      check("wb_data", wb_data_o, exp_data);
      check("wb_rd", 64'(wb_rd_o), 64'(rd));
      check("wb_err", 64'(wb_err_o), 64'(exp_err));
      repeat (hold) begin
         @(posedge clk_i); #1;
      end
      if (hold > 0) begin
         check("hold_wb_valid", 64'(wb_valid_o), 64'd1);
         check("hold_wb_data", wb_data_o, exp_data);
         check("hold_wb_rd", 64'(wb_rd_o), 64'(rd));
         check("hold_not_ready", 64'(req_ready_o), 64'd0);
      end
      @(negedge clk_i);
      wb_ready_i = 1'b1;
      @(posedge clk_i); #1;
      wb_ready_i = 1'b0;
      check("wb_released", 64'(wb_valid_o), 64'd0);
      check("idle_ready", 64'(req_ready_o), 64'd1);
   endtask

   initial begin : timeout_guard
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, observed running expected done");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int          seen;
      logic [5:0]  r_op;
      rst_i        = 1'b1;
      req_valid_i  = 1'b0;
      req_opcode_i = 6'd0;
      req_srcA_i   = 64'd0;
      req_srcB_i   = 64'd0;
      req_rd_i     = 5'd0;
      wb_ready_i   = 1'b0;
      do_reset();

      run_op(6'd0, 64'd5, 64'd7, 5'd3, 0, 1'b1);
      run_op(6'd7, 64'd0, 64'd1, 5'd9, 1, 1'b1);
      run_op(6'h08, 64'd123, 64'd456, 5'd17, 0, 1'b1);
      run_op(6'h3F, 64'hDEAD, 64'hBEEF, 5'd31, 2, 1'b1);
      run_op(6'd6, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'd4, 10, 1'b1);
      run_op(6'd4, 64'h8000_0000_0000_00F0, 64'd63, 5'd5, 0, 1'b1);
      run_op(6'd3, 64'h0000_0000_0000_0001, 64'd63, 5'd6, 0, 1'b1);
      run_op(6'd5, 64'hF000_0000_0000_0000, 64'd4, 5'd7, 0, 1'b1);

      run_op(6'd0, 64'd1, 64'd2, 5'd8, 0, 1'b0);
      alu_respond = 1'b1;
      run_op(6'd2, 64'hF0, 64'h0F, 5'd10, 0, 1'b1);

      // Reset pulse while waiting on the ALU; its late response must not produce writeback
      @(negedge clk_i);
      req_valid_i  = 1'b1;
      req_opcode_i = 6'd0;
      req_srcA_i   = 64'd40;
      req_srcB_i   = 64'd2;
      req_rd_i     = 5'd12;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      #2;
      check("async_rst_ready", 64'(req_ready_o), 64'd0);
      check("async_rst_srcA", alu_srcA_o, 64'd0);
      rst_i = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk_i); #1;
         if (wb_valid_o === 1'b1) seen++;
      end
      check("no_wb_after_mid_reset", 64'(seen), 64'd0);
      run_op(6'd0, 64'd100, 64'd23, 5'd13, 0, 1'b1);

      for (int i = 0; i < 16; i++) begin
         r_op = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(8, 63));
         run_op(r_op, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'($urandom()),
                int'($urandom_range(0, 3)), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
